// File: rtl/huff_pkg.sv
// Shared constants, symbol codes and FSM encoding for the Huffman block assembler.
// Imported by the top-level assembler and the coefficient extender.
package huff_pkg;

    localparam int BLK_LEN  = 64;
    localparam int IDX_W    = $clog2(BLK_LEN);
    localparam int COEFF_W  = 11;
    localparam int RUN_W    = 4;
    localparam int SIZE_W   = 4;
    localparam int RAW_W    = 10;
    localparam int MAX_SIZE = 10;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLK_LEN - 1);

    localparam logic [RUN_W-1:0]  EOB_RUN  = 4'd0;
    localparam logic [SIZE_W-1:0] EOB_SIZE = 4'd0;
    localparam logic [RUN_W-1:0]  ZRL_RUN  = 4'd15;
    localparam logic [SIZE_W-1:0] ZRL_SIZE = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ZEROS = 2'd1,
        ST_COEFF = 2'd2,
        ST_FILL  = 2'd3
    } state_t;

    // Sizes above the largest legal size are handled as the largest legal size.
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] size);
        return (size > SIZE_W'(MAX_SIZE)) ? SIZE_W'(MAX_SIZE) : size;
    endfunction

endpackage

// File: rtl/huff_coeff_extend.sv
// Combinational JPEG-style EXTEND: coefficient size plus raw bitstream bits
// to a signed COEFF_W-bit value.
module huff_coeff_extend
    import huff_pkg::*;
(
    input  logic [SIZE_W-1:0]  coeff_size_i,
    input  logic [RAW_W-1:0]   raw_i,
    output logic [COEFF_W-1:0] value_o
);

    logic [SIZE_W-1:0]  size_eff;
    logic [COEFF_W-1:0] mask;
    logic [COEFF_W-1:0] msb_sel;
    logic [COEFF_W-1:0] raw_masked;

    always_comb begin
        size_eff   = clamp_size(coeff_size_i);
        mask       = (COEFF_W'(1) << size_eff) - COEFF_W'(1);
        msb_sel    = (COEFF_W'(1) << size_eff) >> 1;
        raw_masked = {1'b0, raw_i} & mask;
        // A clear top bit marks a negative value: r - (2^s - 1).
        if (size_eff == '0) begin
            value_o = '0;
        end else if ((raw_masked & msb_sel) != '0) begin
            value_o = raw_masked;
        end else begin
            value_o = raw_masked - mask;
        end
    end

endmodule

// File: rtl/huff_block_assembler.sv
// Expands decoded (run, size, bits) symbols into a serial 64-entry zig-zag
// coefficient block with registered outputs and a sticky overrun flag.
module huff_block_assembler
    import huff_pkg::*;
(
    input  logic                phi1,
    input  logic                reset_b,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic [RUN_W-1:0]    run_length,
    input  logic [SIZE_W-1:0]   coeff_size,
    input  logic [RAW_W-1:0]    coefficient,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COEFF_W-1:0]  out_coeff,
    output logic [IDX_W-1:0]    out_index,
    output logic                out_last,
    output logic                err_overrun,
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; a producer holds its payload stable until that edge.

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4:0]         zcnt_q, zcnt_d;
    logic [COEFF_W-1:0] coeff_q, coeff_d;
    logic               pend_q, pend_d;
    logic               err_q, err_d;

    logic               out_valid_q, out_valid_d;
    logic [COEFF_W-1:0] out_coeff_q, out_coeff_d;
    logic [IDX_W-1:0]   out_index_q, out_index_d;
    logic               out_last_q, out_last_d;

    logic [COEFF_W-1:0] ext_value;
    logic               out_hs;
    logic               at_last;

    huff_coeff_extend u_extend (
        .coeff_size_i (coeff_size),
        .raw_i        (coefficient),
        .value_o      (ext_value)
    );

    assign out_hs  = out_valid_q & out_ready;
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        zcnt_d  = zcnt_q;
        coeff_d = coeff_q;
        pend_d  = pend_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (sym_valid) begin
                    coeff_d = ext_value;
                    pend_d  = 1'b0;
                    if (run_length == EOB_RUN && coeff_size == EOB_SIZE) begin
                        state_d = ST_FILL;
                    end else if (coeff_size == ZRL_SIZE) begin
                        // ZRL (run 15) and the non-standard size-0 runs: run+1 zeros.
                        state_d = ST_ZEROS;
                        zcnt_d  = {1'b0, run_length} + 5'd1;
                    end else if (run_length == '0) begin
                        state_d = ST_COEFF;
                    end else begin
                        state_d = ST_ZEROS;
                        zcnt_d  = {1'b0, run_length};
                        pend_d  = 1'b1;
                    end
                end
            end
            ST_ZEROS: begin
                if (out_hs) begin
                    if (at_last) begin
                        // Anything still owed past the block end is dropped.
                        if (zcnt_q != 5'd1 || pend_q) begin
                            err_d = 1'b1;
                        end
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        zcnt_d = zcnt_q - 5'd1;
                        if (zcnt_q == 5'd1) begin
                            state_d = pend_q ? ST_COEFF : ST_IDLE;
                        end
                    end
                end
            end
            ST_COEFF: begin
                if (out_hs) begin
                    idx_d   = at_last ? '0 : idx_q + IDX_W'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (out_hs) begin
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output register mirrors the item the FSM will present next cycle.
        out_valid_d = (state_d != ST_IDLE);
        out_index_d = idx_d;
        out_coeff_d = (state_d == ST_COEFF) ? coeff_d : '0;
        out_last_d  = (state_d != ST_IDLE) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge phi1 or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            zcnt_q      <= '0;
            coeff_q     <= '0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_coeff_q <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            zcnt_q      <= zcnt_d;
            coeff_q     <= coeff_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_coeff_q <= out_coeff_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    assign sym_ready   = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign out_coeff   = out_coeff_q;
    assign out_index   = out_index_q;
    assign out_last    = out_last_q;
    assign err_overrun = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_huff_block_assembler.sv
// Self-checking bench for huff_block_assembler: directed symbol streams with
// expected outputs queued up front and a monitor that pops on every handshake.
module tb_huff_block_assembler;

    logic        phi1;
    logic        reset_b;
    logic        sym_valid;
    logic        sym_ready;
    logic [3:0]  run_length;
    logic [3:0]  coeff_size;
    logic [9:0]  coefficient;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_coeff;
    logic [5:0]  out_index;
    logic        out_last;
    logic        err_overrun;
    logic [1:0]  dbg_state;

    logic [3:0]  ext_size;
    logic [9:0]  ext_raw;
    logic [10:0] ext_value;

    int          checks;
    int          errors;
    int          hs_count;
    bit          rand_ready;

    logic [17:0] exp_q[$];
    logic [5:0]  exp_idx;
    logic [17:0] mon_act;
    logic [17:0] mon_exp;
    logic [17:0] held;
    bit          held_valid;

    huff_block_assembler dut (
        .phi1        (phi1),
        .reset_b     (reset_b),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .run_length  (run_length),
        .coeff_size  (coeff_size),
        .coefficient (coefficient),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_coeff   (out_coeff),
        .out_index   (out_index),
        .out_last    (out_last),
        .err_overrun (err_overrun),
        .dbg_state   (dbg_state)
    );

    huff_coeff_extend ext_u (
        .coeff_size_i (ext_size),
        .raw_i        (ext_raw),
        .value_o      (ext_value)
    );

    // Clock and watchdog
    initial begin
        phi1 = 1'b0;
        forever #5 phi1 = ~phi1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Downstream ready: always 1, or a 50% coin flip per cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge phi1);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_item(input logic [10:0] v);
        exp_q.push_back({(exp_idx == 6'd63), exp_idx, v});
        exp_idx = exp_idx + 6'd1;
    endtask

    task automatic expect_zeros(input int n);
        for (int i = 0; i < n; i++) expect_item(11'd0);
    endtask

    task automatic send_sym(input logic [3:0] r, input logic [3:0] s, input logic [9:0] c);
        bit done;
        done = 1'b0;
        @(posedge phi1);
        #1;
        sym_valid   = 1'b1;
        run_length  = r;
        coeff_size  = s;
        coefficient = c;
        for (int g = 0; g < 500 && !done; g++) begin
            @(negedge phi1);
            if (sym_ready) begin
                @(posedge phi1);
                #1;
                sym_valid = 1'b0;
                done      = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            sym_valid = 1'b0;
            $display("FAIL sym_accept actual=timeout required=accepted run=%0d size=%0d", r, s);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int g = 0; g < 2000 && !done; g++) begin
            @(negedge phi1);
            #1;
            if (exp_q.size() == 0 && sym_ready) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_%s actual=%0d_pending required=0", name, exp_q.size());
        end
    endtask

    // Monitor: pop and compare on each output handshake; check hold while stalled
    initial begin
        held_valid = 1'b0;
        forever begin
            @(negedge phi1);
            if (!reset_b) begin
                held_valid = 1'b0;
            end else if (out_valid) begin
                mon_act = {out_last, out_index, out_coeff};
                if (held_valid) begin
                    checks++;
                    if (mon_act !== held) begin
                        errors++;
                        $display("FAIL hold actual=%0h required=%0h", mon_act, held);
                    end
                end
                if (out_ready) begin
                    hs_count++;
                    checks++;
                    held_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out actual=%0h required=none", mon_act);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_act !== mon_exp) begin
                            errors++;
                            $display("FAIL out actual=last%0d/idx%0d/%0h required=last%0d/idx%0d/%0h",
                                     mon_act[17], mon_act[16:11], mon_act[10:0],
                                     mon_exp[17], mon_exp[16:11], mon_exp[10:0]);
                        end
                    end
                end else begin
                    held       = mon_act;
                    held_valid = 1'b1;
                end
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    initial begin
        int expv;
        checks      = 0;
        errors      = 0;
        hs_count    = 0;
        rand_ready  = 1'b0;
        exp_idx     = 6'd0;
        reset_b     = 1'b0;
        sym_valid   = 1'b0;
        run_length  = 4'd0;
        coeff_size  = 4'd0;
        coefficient = 10'd0;
        ext_size    = 4'd0;
        ext_raw     = 10'd0;

        // Reset values
        repeat (3) @(posedge phi1);
        #1;
        check("rst_sym_ready", sym_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_coeff", out_coeff, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err_overrun, 0);
        @(posedge phi1);
        #1;
        reset_b = 1'b1;

        // Block A: 3, 0, 0, -1, then EOB fills 60 zeros
        expect_item(11'd3);
        send_sym(4'd0, 4'd2, 10'b11);
        expect_zeros(2);
        expect_item(11'h7FF);
        send_sym(4'd2, 4'd1, 10'b0);
        expect_zeros(60);
        send_sym(4'd0, 4'd0, 10'd0);
        wait_drain("block_a");
        check("a_err", err_overrun, 0);

        // Block B: ZRL x3, then (15,1,1) lands +1 exactly on index 63
        expect_zeros(48);
        repeat (3) send_sym(4'd15, 4'd0, 10'd0);
        expect_zeros(15);
        expect_item(11'd1);
        send_sym(4'd15, 4'd1, 10'd1);
        wait_drain("block_b");
        check("b_err", err_overrun, 0);

        // Block C: reach index 61, then a symbol that runs past 63
        expect_zeros(48);
        repeat (3) send_sym(4'd15, 4'd0, 10'd0);
        expect_zeros(12);
        expect_item(11'd1);
        send_sym(4'd12, 4'd1, 10'd1);
        expect_zeros(3);
        send_sym(4'd15, 4'd4, 10'b0111);
        wait_drain("block_c");
        check("c_err", err_overrun, 1);
        check("c_sym_ready", sym_ready, 1);

        // Reset in the middle of a FILL
        expect_zeros(64);
        send_sym(4'd0, 4'd0, 10'd0);
        repeat (10) @(posedge phi1);
        #3;
        reset_b = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_coeff", out_coeff, 0);
        check("mid_rst_out_index", out_index, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_sym_ready", sym_ready, 1);
        check("mid_rst_err", err_overrun, 0);
        exp_q.delete();
        exp_idx = 6'd0;
        @(posedge phi1);
        #1;
        reset_b = 1'b1;
        repeat (2) @(posedge phi1);
        #1;
        check("post_rst_idle_valid", out_valid, 0);

        // EOB at index 0 with a randomly stalling downstream: 64 zeros from 0
        hs_count   = 0;
        rand_ready = 1'b1;
        expect_zeros(64);
        send_sym(4'd0, 4'd0, 10'd0);
        wait_drain("fill_random");
        rand_ready = 1'b0;
        check("fill_handshakes", hs_count, 64);

        // Non-standard size-0 run and an illegal size clamped to 10
        expect_zeros(4);
        send_sym(4'd3, 4'd0, 10'd0);
        expect_item(11'd1023);
        send_sym(4'd0, 4'd12, 10'h3FF);
        expect_item(11'h401);
        send_sym(4'd0, 4'd10, 10'd0);
        expect_zeros(58);
        send_sym(4'd0, 4'd0, 10'd0);
        wait_drain("block_d");
        check("d_err", err_overrun, 0);

        // Extension sweep against the EXTEND table
        for (int s = 1; s <= 10; s++) begin
            for (int r = 0; r < (1 << s); r++) begin
                ext_size = 4'(s);
                ext_raw  = 10'(r);
                #1;
                expv = (r < (1 << (s - 1))) ? (r - (1 << s) + 1) : r;
                check("extend", {21'd0, ext_value}, {21'd0, 11'(expv)});
            end
        end
        ext_size = 4'd0;  ext_raw = 10'h3FF; #1;
        check("extend_s0", ext_value, 0);
        ext_size = 4'd3;  ext_raw = 10'h3FA; #1;
        check("extend_s3_masked", ext_value, 11'h7FB);
        ext_size = 4'd1;  ext_raw = 10'd0;   #1;
        check("extend_s1_r0", ext_value, 11'h7FF);
        ext_size = 4'd13; ext_raw = 10'h3FF; #1;
        check("extend_s13_max", ext_value, 11'd1023);
        ext_size = 4'd15; ext_raw = 10'd0;   #1;
        check("extend_s15_min", ext_value, 11'h401);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
